// File: rtl/falafel_pkg.sv
// Shared definitions for the falafel memory subsystem: datapath width,
// the memory request record used by the LSU, and a round-robin helper.
package falafel_pkg;

    localparam int DATA_W = 32;

    typedef struct packed {
        logic              is_write;
        logic              is_cas;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    // Successor of channel cur in a ring of n channels.
    function automatic int rr_next(input int cur, input int n);
        return (cur >= n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/falafel_route_fifo.sv
// Small synchronous FIFO holding the owning channel id of every request that
// has been sent to memory and not yet answered. Head is read combinationally.
module falafel_route_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/falafel_mem_mux.sv
// Shares one memory request/response port among NUM_CH requester channels.
// Requests are arbitrated round-robin with a grant lock while stalled; the
// owning channel of each accepted request is queued so that in-order memory
// responses can be steered back to their issuer.
module falafel_mem_mux #(
    parameter int NUM_CH          = 4,
    parameter int DATA_W          = falafel_pkg::DATA_W,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_CH-1:0]             ch_req_val_i,
    output logic [NUM_CH-1:0]             ch_req_rdy_o,
    input  logic [NUM_CH-1:0]             ch_req_is_write_i,
    input  logic [NUM_CH-1:0]             ch_req_is_cas_i,
    input  logic [NUM_CH-1:0][DATA_W-1:0] ch_req_addr_i,
    input  logic [NUM_CH-1:0][DATA_W-1:0] ch_req_data_i,
    output logic [NUM_CH-1:0]             ch_rsp_val_o,
    input  logic [NUM_CH-1:0]             ch_rsp_rdy_i,
    output logic [NUM_CH-1:0][DATA_W-1:0] ch_rsp_data_o,
    output logic                          mem_req_val_o,
    input  logic                          mem_req_rdy_i,
    output logic                          mem_req_is_write_o,
    output logic                          mem_req_is_cas_o,
    output logic [DATA_W-1:0]             mem_req_addr_o,
    output logic [DATA_W-1:0]             mem_req_data_o,
    input  logic                          mem_rsp_val_i,
    output logic                          mem_rsp_rdy_o,
    input  logic [DATA_W-1:0]             mem_rsp_data_i,
    output logic                          err_unexpected_rsp_o
);

    import falafel_pkg::*;

    localparam int CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [CH_W-1:0] lock_ch_q, lock_ch_d;
    logic            err_q, err_d;

    logic [CH_W-1:0] search_ch;
    logic [CH_W-1:0] grant;
    logic            grant_val;
    logic            req_hs;

    logic [CH_W-1:0] head;
    logic            fifo_full, fifo_empty, fifo_pop;

    // Round-robin search: lowest offset from rr_ptr with a valid request wins.
    always_comb begin
        logic [CH_W-1:0] idx;
        idx       = '0;
        search_ch = rr_ptr_q;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
            if (ch_req_val_i[idx]) begin
                search_ch = idx;
            end
        end
    end

    // A stalled grant stays on its channel so the memory port payload is stable.
    assign grant     = lock_q ? lock_ch_q : search_ch;
    assign grant_val = ch_req_val_i[grant];

    assign mem_req_val_o      = grant_val && !fifo_full;
    assign req_hs             = mem_req_val_o && mem_req_rdy_i;
    assign mem_req_is_write_o = ch_req_is_write_i[grant];
    assign mem_req_is_cas_o   = ch_req_is_cas_i[grant];
    assign mem_req_addr_o     = ch_req_addr_i[grant];
    assign mem_req_data_o     = ch_req_data_i[grant];

    // Only the granted channel sees its request accepted.
    always_comb begin
        ch_req_rdy_o        = '0;
        ch_req_rdy_o[grant] = req_hs;
    end

    // Next arbitration pointer, lock and sticky error flag.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (req_hs) begin
            rr_ptr_d = CH_W'(rr_next(int'(grant), NUM_CH));
        end
        lock_d    = mem_req_val_o && !mem_req_rdy_i;
        lock_ch_d = grant;
        err_d     = err_q || (mem_rsp_val_i && fifo_empty);
    end

    // Arbiter and error state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            err_q     <= err_d;
        end
    end

    assign err_unexpected_rsp_o = err_q;

    falafel_route_fifo #(
        .W     (CH_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (req_hs),
        .push_data_i (grant),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // With nothing outstanding no response is accepted and none is forwarded.
    assign mem_rsp_rdy_o = !fifo_empty && ch_rsp_rdy_i[head];
    assign fifo_pop      = mem_rsp_val_i && mem_rsp_rdy_o;

    // Steer response valid to the FIFO head's channel; data goes to everyone.
    always_comb begin
        ch_rsp_val_o       = '0;
        ch_rsp_val_o[head] = mem_rsp_val_i && !fifo_empty;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_rsp_data_o[k] = mem_rsp_data_i;
        end
    end

endmodule

// File: tb/tb_falafel_mem_mux.sv
// Scoreboard bench for falafel_mem_mux: directed requests and responses are
// queued with their expected memory-port and routing results; a monitor pops
// and compares on every handshake.
module tb_falafel_mem_mux;

    localparam int NUM_CH = 4;
    localparam int DW     = 32;

    typedef struct {
        int          ch;
        logic        w;
        logic        cas;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        int          ch;
        logic [DW-1:0] data;
    } rsp_t;

    logic                      clk = 1'b0;
    logic                      rst_ni;
    logic [NUM_CH-1:0]         ch_req_val_i;
    logic [NUM_CH-1:0]         ch_req_rdy_o;
    logic [NUM_CH-1:0]         ch_req_is_write_i;
    logic [NUM_CH-1:0]         ch_req_is_cas_i;
    logic [NUM_CH-1:0][DW-1:0] ch_req_addr_i;
    logic [NUM_CH-1:0][DW-1:0] ch_req_data_i;
    logic [NUM_CH-1:0]         ch_rsp_val_o;
    logic [NUM_CH-1:0]         ch_rsp_rdy_i;
    logic [NUM_CH-1:0][DW-1:0] ch_rsp_data_o;
    logic                      mem_req_val_o;
    logic                      mem_req_rdy_i;
    logic                      mem_req_is_write_o;
    logic                      mem_req_is_cas_o;
    logic [DW-1:0]             mem_req_addr_o;
    logic [DW-1:0]             mem_req_data_o;
    logic                      mem_rsp_val_i;
    logic                      mem_rsp_rdy_o;
    logic [DW-1:0]             mem_rsp_data_i;
    logic                      err_unexpected_rsp_o;

    req_t          chq [NUM_CH][$];
    req_t          exp_req[$];
    rsp_t          exp_rsp[$];
    logic [DW-1:0] rsp_src[$];
    int            outstanding;
    bit            rsp_en;
    bit            force_rsp;
    logic [NUM_CH-1:0] last_ch_hs;
    bit            last_req_hs;
    bit            last_rsp_hs;
    int            vectors;
    int            miscompares;

    falafel_mem_mux #(
        .NUM_CH          (NUM_CH),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .ch_req_val_i         (ch_req_val_i),
        .ch_req_rdy_o         (ch_req_rdy_o),
        .ch_req_is_write_i    (ch_req_is_write_i),
        .ch_req_is_cas_i      (ch_req_is_cas_i),
        .ch_req_addr_i        (ch_req_addr_i),
        .ch_req_data_i        (ch_req_data_i),
        .ch_rsp_val_o         (ch_rsp_val_o),
        .ch_rsp_rdy_i         (ch_rsp_rdy_i),
        .ch_rsp_data_o        (ch_rsp_data_o),
        .mem_req_val_o        (mem_req_val_o),
        .mem_req_rdy_i        (mem_req_rdy_i),
        .mem_req_is_write_o   (mem_req_is_write_o),
        .mem_req_is_cas_o     (mem_req_is_cas_o),
        .mem_req_addr_o       (mem_req_addr_o),
        .mem_req_data_o       (mem_req_data_o),
        .mem_rsp_val_i        (mem_rsp_val_i),
        .mem_rsp_rdy_o        (mem_rsp_rdy_o),
        .mem_rsp_data_i       (mem_rsp_data_i),
        .err_unexpected_rsp_o (err_unexpected_rsp_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: capture handshakes at negedge and compare against the scoreboard.
    initial begin
        req_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                last_ch_hs  = '0;
                last_req_hs = 1'b0;
                last_rsp_hs = 1'b0;
            end else begin
                last_ch_hs  = ch_req_val_i & ch_req_rdy_o;
                last_req_hs = mem_req_val_o && mem_req_rdy_i;
                last_rsp_hs = mem_rsp_val_i && mem_rsp_rdy_o;
                if (last_req_hs) begin
                    if (exp_req.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL req_unexpected: got addr 0x%0h, expected no request", mem_req_addr_o);
                    end else begin
                        e = exp_req.pop_front();
                        check("req_grant", ch_req_rdy_o, 64'(1) << e.ch);
                        check("req_addr", mem_req_addr_o, e.addr);
                        check("req_is_write", mem_req_is_write_o, e.w);
                        check("req_is_cas", mem_req_is_cas_o, e.cas);
                        check("req_data", mem_req_data_o, e.data);
                    end
                end
                if (last_rsp_hs) begin
                    if (exp_rsp.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rsp_unexpected: got route 0x%0h, expected no response", ch_rsp_val_o);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("rsp_route", ch_rsp_val_o, 64'(1) << r.ch);
                        check("rsp_data", ch_rsp_data_o[r.ch], r.data);
                    end
                end
            end
        end
    end

    task automatic drive();
        for (int k = 0; k < NUM_CH; k++) begin
            if (chq[k].size() > 0) begin
                ch_req_val_i[k]      = 1'b1;
                ch_req_is_write_i[k] = chq[k][0].w;
                ch_req_is_cas_i[k]   = chq[k][0].cas;
                ch_req_addr_i[k]     = chq[k][0].addr;
                ch_req_data_i[k]     = chq[k][0].data;
            end else begin
                ch_req_val_i[k]      = 1'b0;
                ch_req_is_write_i[k] = 1'b0;
                ch_req_is_cas_i[k]   = 1'b0;
                ch_req_addr_i[k]     = '0;
                ch_req_data_i[k]     = '0;
            end
        end
        if (force_rsp) begin
            mem_rsp_val_i  = 1'b1;
            mem_rsp_data_i = 32'hDEAD_BEEF;
        end else if (rsp_en && rsp_src.size() > 0 && outstanding > 0) begin
            mem_rsp_val_i  = 1'b1;
            mem_rsp_data_i = rsp_src[0];
        end else begin
            mem_rsp_val_i  = 1'b0;
            mem_rsp_data_i = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (last_ch_hs[k] && chq[k].size() > 0) void'(chq[k].pop_front());
        end
        if (last_req_hs) outstanding++;
        if (last_rsp_hs) begin
            if (rsp_src.size() > 0) void'(rsp_src.pop_front());
            outstanding--;
        end
        drive();
    endtask

    task automatic push_req(input int ch, input logic w, input logic cas,
                            input logic [DW-1:0] addr, input logic [DW-1:0] data);
        req_t q;
        q.ch = ch; q.w = w; q.cas = cas; q.addr = addr; q.data = data;
        chq[ch].push_back(q);
        exp_req.push_back(q);
    endtask

    task automatic push_rsp(input int ch, input logic [DW-1:0] data);
        rsp_t r;
        r.ch = ch; r.data = data;
        rsp_src.push_back(data);
        exp_rsp.push_back(r);
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_req.size() > 0) || (exp_rsp.size() > 0);
        for (int k = 0; k < NUM_CH; k++) begin
            if (chq[k].size() > 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (busy() && n < max_cycles) begin
            step();
            n++;
        end
        if (busy()) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d requests / %0d responses pending, expected 0", name,
                     exp_req.size(), exp_rsp.size());
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        for (int k = 0; k < NUM_CH; k++) chq[k].delete();
        exp_req.delete();
        exp_rsp.delete();
        rsp_src.delete();
        outstanding = 0;
        force_rsp   = 1'b0;
        rsp_en      = 1'b0;
        drive();
        repeat (2) step();
        rst_ni = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mem_req_val"}, mem_req_val_o, 0);
        check({tag, "_ch_req_rdy"}, ch_req_rdy_o, 0);
        check({tag, "_ch_rsp_val"}, ch_rsp_val_o, 0);
        check({tag, "_mem_rsp_rdy"}, mem_rsp_rdy_o, 0);
        check({tag, "_err"}, err_unexpected_rsp_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        last_ch_hs    = '0;
        last_req_hs   = 1'b0;
        last_rsp_hs   = 1'b0;
        mem_req_rdy_i = 1'b1;
        ch_rsp_rdy_i  = '1;
        rst_ni        = 1'b0;

        // Reset state, with memory and channel ready high.
        do_reset();
        @(negedge clk);
        check_idle("reset");

        // All four channels valid back to back: grants 0,1,2,3,0,1,2,3.
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                push_req(k, (k == 1 || k == 3), (k == 3), 32'h100 + k * 16 + j * 4, 32'hA000 + k * 16 + j);
                push_rsp(k, 32'h5000 + j * 4 + k);
            end
        end
        rsp_en = 1'b1;
        drain("rr", 60);

        // Single channel read.
        push_req(2, 1'b0, 1'b0, 32'h40, 32'h0);
        push_rsp(2, 32'h1234);
        drain("single", 20);

        // Grant lock: ch1 stalled for 3 cycles while ch0 joins (rr_ptr now 3).
        rsp_en        = 1'b0;
        mem_req_rdy_i = 1'b0;
        push_req(1, 1'b1, 1'b0, 32'h200, 32'hCAFE_0001);
        push_req(0, 1'b0, 1'b0, 32'h300, 32'h0);
        push_rsp(1, 32'h0000_1111);
        push_rsp(0, 32'h0000_2222);
        chq[0].delete();
        step();
        chq[0].push_back(exp_req[1]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lock_val", mem_req_val_o, 1);
            check("lock_addr", mem_req_addr_o, 32'h200);
            check("lock_data", mem_req_data_o, 32'hCAFE_0001);
            step();
        end
        mem_req_rdy_i = 1'b1;
        rsp_en        = 1'b1;
        drain("lock", 30);

        // Full FIFO: four accepted, fifth blocked until a response frees a slot.
        rsp_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_req(0, 1'b0, 1'b0, 32'h400 + i * 4, 32'h0);
            push_rsp(0, 32'h6000 + i);
        end
        repeat (4) step();
        rsp_en = 1'b1;
        step();
        @(negedge clk);
        check("full_req_val", mem_req_val_o, 0);
        check("full_rsp_rdy", mem_rsp_rdy_o, 1);
        check("full_rsp_route", ch_rsp_val_o, 4'b0001);
        step();
        @(negedge clk);
        check("freed_req_val", mem_req_val_o, 1);
        check("freed_req_addr", mem_req_addr_o, 32'h410);
        drain("full", 30);

        // Response backpressure on ch3 with a ch1 entry queued behind it.
        rsp_en = 1'b0;
        push_req(3, 1'b0, 1'b0, 32'h500, 32'h0);
        step();
        push_req(1, 1'b0, 1'b0, 32'h504, 32'h0);
        step();
        push_rsp(3, 32'h7003);
        push_rsp(1, 32'h7001);
        ch_rsp_rdy_i[3] = 1'b0;
        rsp_en          = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            check("bp_route", ch_rsp_val_o, 4'b1000);
            check("bp_rsp_rdy", mem_rsp_rdy_o, 0);
        end
        step();
        ch_rsp_rdy_i[3] = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", mem_rsp_rdy_o, 1);
        step();
        @(negedge clk);
        check("bp_next_route", ch_rsp_val_o, 4'b0010);
        drain("bp", 20);

        // Unexpected response with nothing outstanding.
        force_rsp = 1'b1;
        step();
        @(negedge clk);
        check("unexp_rsp_rdy", mem_rsp_rdy_o, 0);
        check("unexp_route", ch_rsp_val_o, 0);
        force_rsp = 1'b0;
        step();
        @(negedge clk);
        check("err_set", err_unexpected_rsp_o, 1);
        repeat (3) step();
        @(negedge clk);
        check("err_sticky", err_unexpected_rsp_o, 1);

        do_reset();
        @(negedge clk);
        check_idle("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
